// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute sequencer, IR[15:12] decode, datapath
// enables/selects and ready-based memory handshake. Outputs are decoded
// combinationally from state and inputs, and gated to 0 while nReset is low.
// Optional feature macro: MU0_CTRL_PERF_CNT_EN adds the Instr_count retired-
// instruction counter.
module mu0_control #(
  parameter int unsigned OPC_W = 4
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             N,
  input  logic             Z,
  input  logic             Mem_ready,
  output logic             MEM_rd,
  output logic             MEM_wr,
  output logic             IR_En,
  output logic             PC_En,
  output logic             Acc_En,
  output logic             Addr_sel,
  output logic             X_sel,
  output logic             Y_sel,
  output logic [1:0]       ALU_fs,
  output logic             Halted
`ifdef MU0_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]      Instr_count
`endif
);

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_JGE = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JNE = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_STP = OPC_W'(7);

  localparam logic [1:0] FS_Y   = 2'b00;
  localparam logic [1:0] FS_ADD = 2'b01;
  localparam logic [1:0] FS_INC = 2'b10;
  localparam logic [1:0] FS_SUB = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_rd, w_mem_wr, w_ir_en, w_pc_en, w_acc_en;
  logic       w_addr_sel, w_x_sel, w_y_sel, w_halted;
  logic [1:0] w_alu_fs;

  // State register, async-cleared to FETCH
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  // Next-state and control decode
  always_comb begin
    w_next     = r_state;
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_ir_en    = 1'b0;
    w_pc_en    = 1'b0;
    w_acc_en   = 1'b0;
    w_addr_sel = 1'b0;
    w_x_sel    = 1'b0;
    w_y_sel    = 1'b0;
    w_alu_fs   = FS_Y;
    w_halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC addresses memory while the ALU computes PC+1 in parallel
        w_mem_rd = 1'b1;
        w_x_sel  = 1'b1;
        w_alu_fs = FS_INC;
        if (Mem_ready) begin
          w_ir_en = 1'b1;
          w_pc_en = 1'b1;
          w_next  = S_EXEC;
        end
      end
      S_EXEC: begin
        case (Opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            w_addr_sel = 1'b1;
            w_mem_rd   = 1'b1;
            w_alu_fs   = (Opcode == OP_LDA) ? FS_Y :
                         (Opcode == OP_ADD) ? FS_ADD : FS_SUB;
            if (Mem_ready) begin
              w_acc_en = 1'b1;
              w_next   = S_FETCH;
            end
          end
          OP_STA: begin
            w_addr_sel = 1'b1;
            w_mem_wr   = 1'b1;
            if (Mem_ready) w_next = S_FETCH;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            // Target comes straight from IR[11:0] through the ALU
            w_y_sel = 1'b1;
            w_pc_en = (Opcode == OP_JMP) |
                      ((Opcode == OP_JGE) & ~N) |
                      ((Opcode == OP_JNE) & ~Z);
            w_next  = S_FETCH;
          end
          OP_STP:  w_next = S_HALT;
          default: w_next = S_FETCH;
        endcase
      end
      S_HALT:  w_halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every control output low immediately
  assign MEM_rd   = nReset & w_mem_rd;
  assign MEM_wr   = nReset & w_mem_wr;
  assign IR_En    = nReset & w_ir_en;
  assign PC_En    = nReset & w_pc_en;
  assign Acc_En   = nReset & w_acc_en;
  assign Addr_sel = nReset & w_addr_sel;
  assign X_sel    = nReset & w_x_sel;
  assign Y_sel    = nReset & w_y_sel;
  assign ALU_fs   = nReset ? w_alu_fs : 2'b00;
  assign Halted   = nReset & w_halted;

`ifdef MU0_CTRL_PERF_CNT_EN
  logic [15:0] r_instr_count;
  logic        w_retire;

  assign w_retire = (r_state == S_EXEC) && (w_next != S_EXEC);

  // Retired-instruction counter; naturally frozen once in HALT
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)       r_instr_count <= 16'd0;
    else if (w_retire) r_instr_count <= r_instr_count + 16'd1;
  end

  assign Instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: directed vector table, multi-cycle
// reset sequences, and randomized run against an instruction-level model.
module tb_mu0_control;

  logic       Clk;
  logic       nReset;
  logic [3:0] Opcode;
  logic       N, Z, Mem_ready;
  logic       MEM_rd, MEM_wr, IR_En, PC_En, Acc_En;
  logic       Addr_sel, X_sel, Y_sel, Halted;
  logic [1:0] ALU_fs;
`ifdef MU0_CTRL_PERF_CNT_EN
  logic [15:0] Instr_count;
`endif

  mu0_control #(.OPC_W(4)) dut (
    .Clk(Clk), .nReset(nReset), .Opcode(Opcode), .N(N), .Z(Z),
    .Mem_ready(Mem_ready), .MEM_rd(MEM_rd), .MEM_wr(MEM_wr),
    .IR_En(IR_En), .PC_En(PC_En), .Acc_En(Acc_En), .Addr_sel(Addr_sel),
    .X_sel(X_sel), .Y_sel(Y_sel), .ALU_fs(ALU_fs), .Halted(Halted)
`ifdef MU0_CTRL_PERF_CNT_EN
    , .Instr_count(Instr_count)
`endif
  );

  always #5 Clk = ~Clk;

  // Output vector layout: rd wr ir pc acc addr x y fs[1:0] halted
  logic [10:0] act;
  assign act = {MEM_rd, MEM_wr, IR_En, PC_En, Acc_En, Addr_sel, X_sel, Y_sel, ALU_fs, Halted};

  localparam logic [10:0] M_ALL = 11'h7FF;
  localparam logic [10:0] M_EN  = 11'b111_1100_0001;
  localparam logic [10:0] B_A   = 11'b000_0010_0000;
  localparam logic [10:0] B_X   = 11'b000_0001_0000;
  localparam logic [10:0] B_Y   = 11'b000_0000_1000;
  localparam logic [10:0] B_FS  = 11'b000_0000_0110;

  int checks;
  int failures;

  // Instruction-level model: IR loaded or not, stopped or not, retire count
  bit          m_ir_loaded;
  bit          m_stopped;
  logic [15:0] m_count;

  function automatic logic [10:0] mk(bit rd, bit wr, bit ir, bit pc, bit acc,
                                      bit as, bit xs, bit ys, logic [1:0] fs, bit h);
    return {rd, wr, ir, pc, acc, as, xs, ys, fs, h};
  endfunction

  task automatic check(input string name, input logic [10:0] e, input logic [10:0] m);
    checks++;
    if ((act & m) !== (e & m)) begin
      failures++;
      $display("FAIL %s t=%0t: got %b expected %b (mask %b)", name, $time, act, e, m);
    end
  endtask

  task automatic check_count(input string name, input logic [15:0] e);
`ifdef MU0_CTRL_PERF_CNT_EN
    checks++;
    if (Instr_count !== e) begin
      failures++;
      $display("FAIL %s t=%0t: Instr_count got %h expected %h", name, $time, Instr_count, e);
    end
`endif
  endtask

  // Expected outputs derived from the instruction semantics
  task automatic model_exp(input logic [3:0] opc, input bit n, input bit z, input bit rdy,
                           output logic [10:0] e, output logic [10:0] m);
    int op;
    op = int'(opc);
    if (m_stopped) begin
      e = mk(0,0,0,0,0,0,0,0,2'b00,1); m = M_ALL;
    end else if (!m_ir_loaded) begin
      e = mk(1,0,rdy,rdy,0,0,1,0,2'b10,0); m = M_ALL & ~B_Y;
    end else if (op <= 3) begin
      bit is_rd;
      logic [1:0] fs;
      is_rd = (op != 1);
      fs = (op == 0) ? 2'b00 : (op == 2) ? 2'b01 : 2'b11;
      e = mk(is_rd, !is_rd, 0, 0, is_rd && rdy, 1, 0, 0, fs, 0);
      m = (op == 1) ? (M_EN | B_A) : (op == 0) ? (M_ALL & ~B_X) : M_ALL;
    end else if (op <= 6) begin
      bit taken;
      taken = (op == 4) || (op == 5 && !n) || (op == 6 && !z);
      e = mk(0,0,0,taken,0,0,0,1,2'b00,0); m = M_EN | B_Y | B_FS;
    end else begin
      e = 11'd0; m = M_EN;
    end
  endtask

  task automatic model_step(input logic [3:0] opc, input bit rdy);
    int op;
    op = int'(opc);
    if (m_stopped) return;
    if (!m_ir_loaded) begin
      if (rdy) m_ir_loaded = 1;
    end else if (op <= 3) begin
      if (rdy) begin m_ir_loaded = 0; m_count = m_count + 16'd1; end
    end else if (op == 7) begin
      m_stopped = 1; m_ir_loaded = 0; m_count = m_count + 16'd1;
    end else begin
      m_ir_loaded = 0; m_count = m_count + 16'd1;
    end
  endtask

  // One clock: drive at posedge+1, check mid-cycle, advance model at posedge
  task automatic cyc(input logic [3:0] opc, input bit n, input bit z, input bit rdy,
                     input bit use_tab, input logic [10:0] te, input logic [10:0] tm,
                     input string name);
    logic [10:0] e, m;
    Opcode = opc; N = n; Z = z; Mem_ready = rdy;
    #3;
    if (use_tab) check(name, te, tm);
    else begin
      model_exp(opc, n, z, rdy, e, m);
      check(name, e, m);
    end
    check_count({name, "_cnt"}, m_count);
    model_step(opc, rdy);
    @(posedge Clk); #1;
  endtask

  task automatic do_reset(input string name);
    nReset = 0;
    #1;
    check({name, "_zero"}, 11'd0, M_ALL);
    check_count({name, "_cnt0"}, 16'd0);
    @(posedge Clk); @(posedge Clk); #1;
    nReset = 1;
    m_ir_loaded = 0; m_stopped = 0; m_count = 16'd0;
  endtask

  typedef struct {
    logic [3:0]  opc;
    bit          n, z, rdy;
    logic [10:0] e, m;
    string       name;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t v(logic [3:0] opc, bit n, bit z, bit rdy,
                             logic [10:0] e, logic [10:0] m, string name);
    vec_t r;
    r.opc = opc; r.n = n; r.z = z; r.rdy = rdy; r.e = e; r.m = m; r.name = name;
    return r;
  endfunction

  initial begin
    logic [10:0] f_go, f_wait, m_f;
    logic [3:0]  cur_opc;
    Clk = 0; nReset = 0; Opcode = 0; N = 0; Z = 0; Mem_ready = 0;
    checks = 0; failures = 0;
    m_ir_loaded = 0; m_stopped = 0; m_count = 0;

    f_go   = mk(1,0,1,1,0,0,1,0,2'b10,0);
    f_wait = mk(1,0,0,0,0,0,1,0,2'b10,0);
    m_f    = M_ALL & ~B_Y;

    tab.push_back(v(4'd0,0,0,1, f_go, m_f, "fetch_lda"));
    tab.push_back(v(4'd0,0,0,1, mk(1,0,0,0,1,1,0,0,2'b00,0), M_ALL & ~B_X, "exec_lda"));
    tab.push_back(v(4'd5,0,0,1, f_go, m_f, "fetch_jge"));
    tab.push_back(v(4'd5,0,0,1, mk(0,0,0,1,0,0,0,1,2'b00,0), M_EN|B_Y|B_FS, "jge_n0_taken"));
    tab.push_back(v(4'd5,1,0,1, f_go, m_f, "fetch_jge2"));
    tab.push_back(v(4'd5,1,0,1, 11'd0, M_EN, "jge_n1_not_taken"));
    tab.push_back(v(4'd6,0,1,1, f_go, m_f, "fetch_jne"));
    tab.push_back(v(4'd6,0,1,1, 11'd0, M_EN, "jne_z1_not_taken"));
    tab.push_back(v(4'd6,0,0,1, f_go, m_f, "fetch_jne2"));
    tab.push_back(v(4'd6,0,0,0, mk(0,0,0,1,0,0,0,1,2'b00,0), M_EN|B_Y|B_FS, "jne_z0_taken_noready"));
    tab.push_back(v(4'd1,0,0,1, f_go, m_f, "fetch_sta"));
    for (int i = 0; i < 3; i++)
      tab.push_back(v(4'd1,0,0,0, mk(0,1,0,0,0,1,0,0,2'b00,0), M_EN|B_A, "sta_wait"));
    tab.push_back(v(4'd1,0,0,1, mk(0,1,0,0,0,1,0,0,2'b00,0), M_EN|B_A, "sta_done"));
    tab.push_back(v(4'd2,0,0,0, f_wait, m_f, "fetch_wait"));
    tab.push_back(v(4'd2,0,0,1, f_go, m_f, "fetch_add"));
    tab.push_back(v(4'd2,0,0,1, mk(1,0,0,0,1,1,0,0,2'b01,0), M_ALL, "exec_add"));
    tab.push_back(v(4'd3,0,0,1, f_go, m_f, "fetch_sub"));
    tab.push_back(v(4'd3,0,0,1, mk(1,0,0,0,1,1,0,0,2'b11,0), M_ALL, "exec_sub"));
    tab.push_back(v(4'd4,0,0,1, f_go, m_f, "fetch_jmp"));
    tab.push_back(v(4'd4,1,1,0, mk(0,0,0,1,0,0,0,1,2'b00,0), M_EN|B_Y|B_FS, "exec_jmp"));
    tab.push_back(v(4'd9,0,0,1, f_go, m_f, "fetch_nop"));
    tab.push_back(v(4'd9,0,0,1, 11'd0, M_EN, "exec_nop"));
    tab.push_back(v(4'd7,0,0,1, f_go, m_f, "fetch_stp"));
    tab.push_back(v(4'd7,0,0,1, 11'd0, M_EN, "exec_stp"));
    tab.push_back(v(4'd0,0,0,1, mk(0,0,0,0,0,0,0,0,2'b00,1), M_ALL, "halt_first"));

    @(posedge Clk); #1;
    do_reset("reset_init");

    foreach (tab[i])
      cyc(tab[i].opc, tab[i].n, tab[i].z, tab[i].rdy, 1, tab[i].e, tab[i].m, tab[i].name);

    // Halt holds for 20 cycles regardless of inputs
    for (int i = 0; i < 20; i++)
      cyc(4'($urandom_range(0,15)), 1'($urandom), 1'($urandom), 1'($urandom), 1,
          mk(0,0,0,0,0,0,0,0,2'b00,1), M_ALL, "halt_hold");
    do_reset("reset_in_halt");
    cyc(4'd0,0,0,0, 1, f_wait, m_f, "fetch_after_reset");

    // Reset mid-transaction drops the read request asynchronously
    Opcode = 4'd0; Mem_ready = 0;
    #2;
    check("mid_txn_before_reset", f_wait, m_f);
    nReset = 0;
    #1;
    check("mid_txn_request_drop", 11'd0, M_ALL);
    @(posedge Clk); @(posedge Clk); #1;
    nReset = 1;
    m_ir_loaded = 0; m_stopped = 0; m_count = 16'd0;

    // Randomized run against the model; opcode only changes at fetch
    cur_opc = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if (m_stopped && $urandom_range(0,3) == 0) begin
        do_reset("rand_reset_halt");
      end else if ($urandom_range(0,199) == 0) begin
        do_reset("rand_reset");
      end else begin
        if (!m_ir_loaded) begin
          cur_opc = 4'($urandom_range(0,15));
          if (cur_opc == 4'd7 && $urandom_range(0,3) != 0) cur_opc = 4'd8;
        end
        cyc(cur_opc, 1'($urandom), 1'($urandom), ($urandom_range(0,2) != 0), 0,
            11'd0, 11'd0, "rand");
      end
    end

`ifdef MU0_CTRL_PERF_CNT_EN
    do_reset("perf_reset");
    for (int i = 0; i < 65535; i++) begin
      cyc(4'd8,0,0,1, 0, 11'd0, 11'd0, "nop_fetch");
      cyc(4'd8,0,0,1, 0, 11'd0, 11'd0, "nop_exec");
    end
    check_count("count_ffff", 16'hFFFF);
    cyc(4'd8,0,0,1, 0, 11'd0, 11'd0, "nop_fetch");
    cyc(4'd8,0,0,1, 0, 11'd0, 11'd0, "nop_exec");
    check_count("count_wrap", 16'h0000);
    cyc(4'd8,0,0,1, 0, 11'd0, 11'd0, "nop_fetch");
    cyc(4'd8,0,0,1, 0, 11'd0, 11'd0, "nop_exec");
    cyc(4'd0,0,0,0, 0, 11'd0, 11'd0, "fetch_wait_pre_reset");
    check_count("count_one", 16'h0001);
    do_reset("reset_in_fetch_wait");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
